// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state set, table-width
// derivation and the supported parameter limits.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_IN_MAX   = 6;
  localparam int SETTLE_MAX = 255;

  // Truth-table width for an n-input circuit.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_priority_encoder.sv
// Lowest-set-bit priority encoder over a truth-table-wide mask; reports the
// bit index and whether any bit is set (index is 0 when none are).
module tt_priority_encoder
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic [TT_W-1:0] mask,
  output logic [N_IN-1:0] idx,
  output logic            any
);

  always_comb begin
    // NOTE: defaults first so no path leaves idx/any unassigned (no latch);
    // blocking assignments let the downward scan end on the lowest set bit.
    idx = '0;
    any = 1'b0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = N_IN'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a small combinational circuit, samples its
// output after a settle delay and compares the recovered table to an expected ID.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] result,
  output logic            match,
  output logic [TT_W-1:0] mismatch_mask,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [1:0]    S_IDLE   = IDLE;
  localparam logic [1:0]    S_APPLY  = APPLY;
  localparam logic [1:0]    S_DONE   = DONE;
  localparam logic [7:0]    SETTLE   = 8'(SETTLE_CYCLES);
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TT_W - 1);

  logic [1:0]      state;
  logic [N_IN:0]   idx;
  logic [7:0]      cnt;
  logic [TT_W-1:0] exp_q;
  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] tt_next;
  logic [TT_W-1:0] mask_next;
  logic [N_IN-1:0] enc_idx;
  logic            enc_any;

  // Table as it will look once the current sample lands; the final vector's
  // bit must be included when the results are published on entry to DONE.
  always_comb begin
    tt_next = tt_q;
    tt_next[idx[N_IN-1:0]] = resp;
  end

  assign mask_next = tt_next ^ exp_q;

  tt_priority_encoder #(.N_IN(N_IN)) u_fail_enc (
    .mask (mask_next),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Decoded from state so an asynchronous reset clears them immediately.
  assign stim = (state == S_APPLY) ? idx[N_IN-1:0] : '0;
  assign busy = (state == S_APPLY);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments only; the table is
  // small flop storage, so it is reset with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      tt_q          <= '0;
      result        <= '0;
      match         <= 1'b0;
      mismatch_mask <= '0;
      fail_idx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_q <= expected;
            tt_q  <= '0;
            idx   <= '0;
            cnt   <= SETTLE;
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            tt_q <= tt_next;
            if (idx == LAST_IDX) begin
              result        <= tt_next;
              mismatch_mask <= mask_next;
              match         <= ~enc_any;
              fail_idx      <= enc_idx;
              state         <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
              cnt <= SETTLE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
